// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_ctrl
// Description : Multi-channel LED pattern engine with a shared tick prescaler.
//               Each channel runs OFF / ON / BLINK / BURST patterns, configured
//               through a valid/ready port with a single staging register.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1000,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    input  logic [7:0]       cfg_count,
    output logic [N_CH-1:0]  led,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  done
);

    localparam int         PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOLID = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------------
    logic [PS_W-1:0] ps_q;
    logic            w_tick;

    assign w_tick = (ps_q == PS_LAST);

    // Free-running base-tick divider; never disturbed by configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else if (w_tick) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Configuration handshake and staging register
    // ------------------------------------------------------------------------
    logic             ready_q;
    logic             stg_vld_q;
    logic [CH_W-1:0]  stg_ch_q;
    logic [1:0]       stg_mode_q;
    logic [CNT_W-1:0] stg_on_q;
    logic [CNT_W-1:0] stg_off_q;
    logic [7:0]       stg_count_q;
    logic             w_accept;

    assign w_accept  = cfg_valid & ready_q;
    assign cfg_ready = ready_q;

    // Capture one request; ready drops for the cycle the staged entry is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b0;
            stg_vld_q   <= 1'b0;
            stg_ch_q    <= '0;
            stg_mode_q  <= MODE_OFF;
            stg_on_q    <= '0;
            stg_off_q   <= '0;
            stg_count_q <= '0;
        end else begin
            ready_q   <= ~w_accept;
            stg_vld_q <= w_accept;
            if (w_accept) begin
                stg_ch_q    <= cfg_ch;
                stg_mode_q  <= cfg_mode;
                // A zero-length phase is stretched to one tick.
                stg_on_q    <= (cfg_on  == '0) ? CNT_W'(1) : cfg_on;
                stg_off_q   <= (cfg_off == '0) ? CNT_W'(1) : cfg_off;
                stg_count_q <= cfg_count;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel pattern FSMs
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] on_len_q, on_len_d;
        logic [CNT_W-1:0] off_len_q, off_len_d;
        logic [7:0]       pulse_q, pulse_d;
        logic             burst_q, burst_d;
        logic             done_ev_q, done_ev_d;
        logic             led_q, busy_q, done_q;
        logic             w_load;

        // Out-of-range channel indices never match, so they are dropped here.
        assign w_load = stg_vld_q && (stg_ch_q == CH_W'(g));

        // Next-state logic: a load always wins over tick-driven progress.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            on_len_d  = on_len_q;
            off_len_d = off_len_q;
            pulse_d   = pulse_q;
            burst_d   = burst_q;
            done_ev_d = 1'b0;
            if (w_load) begin
                on_len_d  = stg_on_q;
                off_len_d = stg_off_q;
                cnt_d     = stg_on_q;
                pulse_d   = stg_count_q;
                burst_d   = 1'b0;
                case (stg_mode_q)
                    MODE_OFF:   state_d = ST_IDLE;
                    MODE_ON:    state_d = ST_SOLID;
                    MODE_BLINK: state_d = ST_ON;
                    default: begin
                        burst_d = 1'b1;
                        if (stg_count_q == 8'd0) begin
                            state_d   = ST_DONE;
                            done_ev_d = 1'b1;
                        end else begin
                            state_d = ST_ON;
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    ST_IDLE, ST_SOLID, ST_DONE: begin
                        state_d = state_q;
                    end
                    ST_ON: begin
                        if (w_tick) begin
                            if (cnt_q == CNT_W'(1)) begin
                                state_d = ST_OFF;
                                cnt_d   = off_len_q;
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    ST_OFF: begin
                        if (w_tick) begin
                            if (cnt_q == CNT_W'(1)) begin
                                if (burst_q && (pulse_q == 8'd1)) begin
                                    pulse_d   = 8'd0;
                                    state_d   = ST_DONE;
                                    done_ev_d = 1'b1;
                                end else begin
                                    if (burst_q) begin
                                        pulse_d = pulse_q - 8'd1;
                                    end
                                    state_d = ST_ON;
                                    cnt_d   = on_len_q;
                                end
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // State register plus registered output decode one cycle behind.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                on_len_q  <= '0;
                off_len_q <= '0;
                pulse_q   <= '0;
                burst_q   <= 1'b0;
                done_ev_q <= 1'b0;
                led_q     <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                on_len_q  <= on_len_d;
                off_len_q <= off_len_d;
                pulse_q   <= pulse_d;
                burst_q   <= burst_d;
                done_ev_q <= done_ev_d;
                led_q     <= (state_q == ST_SOLID) || (state_q == ST_ON);
                busy_q    <= burst_q && ((state_q == ST_ON) || (state_q == ST_OFF));
                done_q    <= done_ev_q;
            end
        end

        assign led[g]  = led_q;
        assign busy[g] = busy_q;
        assign done[g] = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Directed self-checking bench for led_pattern_ctrl with a
//               per-cycle expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_BURST = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_on = '0, cfg_off = '0, cfg_count = '0;
    logic [3:0] led, busy, done;

    logic       cfg_valid5 = 1'b0;
    logic       cfg_ready5;
    logic [2:0] cfg_ch5 = '0;
    logic [4:0] led5, busy5, done5;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [3:0] busy;
        logic [3:0] done;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    led_pattern_ctrl #(.N_CH(4), .CNT_W(8), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .cfg_count(cfg_count), .led(led), .busy(busy), .done(done)
    );

    // Five-channel instance so that an out-of-range index (5) is representable.
    led_pattern_ctrl #(.N_CH(5), .CNT_W(8), .PRESCALE(1)) u_dut5 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
        .cfg_ch(cfg_ch5), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .cfg_count(cfg_count), .led(led5), .busy(busy5), .done(done5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] l, input logic [3:0] b,
                        input logic [3:0] d);
        exp_t e;
        e.tag  = tag;
        e.led  = l;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    // One queue entry per clock: {done,busy,led} after each edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            chk(e.tag, {20'd0, done, busy, led}, {20'd0, e.done, e.busy, e.led});
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (cfg_ready !== 1'b1) chk("ready_timeout", {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic send(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] on,
                        input logic [7:0] off, input logic [7:0] cnt);
        wait_ready();
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_on    = on;
        cfg_off   = off;
        cfg_count = cnt;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_outs", {20'd0, done, busy, led}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_outs5", {17'd0, done5, busy5, led5}, 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);

        // BLINK ch0 on=2 off=3: 1,1,0,0,0 from the second edge after accept
        send(2'd0, M_BLINK, 8'd2, 8'd3, 8'd0);
        push("blink_e1", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 10; k++)
            push($sformatf("blink_c%0d", k), ((k % 5) < 2) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
        drain();
        send(2'd0, M_OFF, 8'd1, 8'd1, 8'd0);
        repeat (3) step();

        // BURST ch1 on=1 off=1 count=3
        send(2'd1, M_BURST, 8'd1, 8'd1, 8'd3);
        push("burst_e1", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++)
            push($sformatf("burst_c%0d", k), ((k % 2) == 0) ? 4'b0010 : 4'b0000, 4'b0010, 4'b0000);
        push("burst_done", 4'b0000, 4'b0000, 4'b0010);
        push("burst_hold0", 4'b0000, 4'b0000, 4'b0000);
        push("burst_hold1", 4'b0000, 4'b0000, 4'b0000);
        drain();

        // BURST count=0 on ch2: immediate done, no light
        send(2'd2, M_BURST, 8'd1, 8'd1, 8'd0);
        push("cnt0_e1", 4'b0000, 4'b0000, 4'b0000);
        push("cnt0_done", 4'b0000, 4'b0000, 4'b0100);
        push("cnt0_hold0", 4'b0000, 4'b0000, 4'b0000);
        push("cnt0_hold1", 4'b0000, 4'b0000, 4'b0000);
        drain();

        // Zero phase lengths on ch3 act as one tick
        send(2'd3, M_BURST, 8'd0, 8'd0, 8'd1);
        push("zero_e1", 4'b0000, 4'b0000, 4'b0000);
        push("zero_on", 4'b1000, 4'b1000, 4'b0000);
        push("zero_off", 4'b0000, 4'b1000, 4'b0000);
        push("zero_done", 4'b0000, 4'b0000, 4'b1000);
        push("zero_hold", 4'b0000, 4'b0000, 4'b0000);
        drain();

        // Handshake with cfg_valid held: accepts on alternate cycles
        wait_ready();
        cfg_mode = M_ON; cfg_on = 8'd1; cfg_off = 8'd1; cfg_count = 8'd0;
        cfg_ch = 2'd0; cfg_valid = 1'b1;
        step(); chk("hs_rdy0", {31'd0, cfg_ready}, 32'd0);
        cfg_ch = 2'd2;
        step(); chk("hs_rdy1", {31'd0, cfg_ready}, 32'd1);
        step(); chk("hs_rdy2", {31'd0, cfg_ready}, 32'd0);
        cfg_ch = 2'd3;
        step(); chk("hs_rdy3", {31'd0, cfg_ready}, 32'd1);
        step(); chk("hs_rdy4", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        step(); chk("hs_rdy5", {31'd0, cfg_ready}, 32'd1);
        step();
        step(); chk("hs_leds", {28'd0, led}, 32'h0000000D);
        send(2'd0, M_OFF, 8'd1, 8'd1, 8'd0);
        send(2'd2, M_OFF, 8'd1, 8'd1, 8'd0);
        send(2'd3, M_OFF, 8'd1, 8'd1, 8'd0);
        repeat (3) step();
        chk("hs_cleared", {20'd0, done, busy, led}, 32'd0);

        // Out-of-range channel on the five-channel instance is ignored
        cfg_mode = M_ON; cfg_ch5 = 3'd5; cfg_valid5 = 1'b1;
        step();
        cfg_valid5 = 1'b0;
        chk("ign_accepted", {31'd0, cfg_ready5}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ign_outs%0d", k), {17'd0, done5, busy5, led5}, 32'd0);
        end
        cfg_ch5 = 3'd4; cfg_valid5 = 1'b1;
        step();
        cfg_valid5 = 1'b0;
        step(); step();
        chk("ign_ch4_on", {27'd0, led5}, 32'h00000010);

        // Abort: ch1 burst reconfigured to ON before completing
        send(2'd1, M_BURST, 8'd4, 8'd4, 8'd3);
        send(2'd1, M_ON, 8'd1, 8'd1, 8'd0);
        push("abort_e1", 4'b0010, 4'b0010, 4'b0000);
        for (int k = 0; k < 6; k++)
            push($sformatf("abort_c%0d", k), 4'b0010, 4'b0000, 4'b0000);
        drain();

        // Reset during BLINK
        send(2'd0, M_BLINK, 8'd2, 8'd3, 8'd0);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rstmid_outs", {20'd0, done, busy, led}, 32'd0);
        chk("rstmid_ready", {31'd0, cfg_ready}, 32'd0);
        step();
        chk("rstmid_outs2", {20'd0, done, busy, led}, 32'd0);
        rst = 1'b0;
        step();
        chk("rstmid_ready_back", {31'd0, cfg_ready}, 32'd1);
        repeat (3) step();
        chk("rstmid_idle", {20'd0, done, busy, led}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
